// File: rtl/product_accumulator.sv
// Burst accumulator for unsigned products: sums terms until in_last, then holds the
// total, saturating term count and sticky carry flag behind a valid/ready handshake.
module product_accumulator #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o
);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [ACC_W:0]   add_full;
    logic [CNT_W-1:0] cnt_inc;
    logic             xfer;

    assign xfer = in_valid_i && in_ready_q;

    always_comb begin
        add_full = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data_i};
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // in_data_i is only ever captured under xfer, so an X on an idle cycle never lands in state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (xfer) begin
                        if (in_last_i) begin
                            out_sum_q   <= add_full[ACC_W-1:0];
                            out_count_q <= cnt_inc;
                            out_ovf_q   <= ovf_q | add_full[ACC_W];
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            ovf_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= StHold;
                        end else begin
                            acc_q <= add_full[ACC_W-1:0];
                            cnt_q <= cnt_inc;
                            ovf_q <= ovf_q | add_full[ACC_W];
                        end
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_count_o = out_count_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives three parameterisations in lockstep and checks each result against totals
// computed from the burst contents with plain arithmetic.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_ovf;
    logic [15:0] a_sum;
    logic [7:0]  a_cnt;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [7:0]  b_sum;
    logic [7:0]  b_cnt;
    logic        c_in_ready, c_out_valid, c_ovf;
    logic [15:0] c_sum;
    logic [1:0]  c_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    byte unsigned terms[$];

    always #5 clk = ~clk;

    product_accumulator #(.IN_W(8), .ACC_W(16), .CNT_W(8)) u_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_last_i(in_last), .in_ready_o(a_in_ready), .out_valid_o(a_out_valid),
        .out_ready_i(out_ready), .out_sum_o(a_sum), .out_count_o(a_cnt), .out_ovf_o(a_ovf)
    );
    product_accumulator #(.IN_W(8), .ACC_W(8), .CNT_W(8)) u_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_last_i(in_last), .in_ready_o(b_in_ready), .out_valid_o(b_out_valid),
        .out_ready_i(out_ready), .out_sum_o(b_sum), .out_count_o(b_cnt), .out_ovf_o(b_ovf)
    );
    product_accumulator #(.IN_W(8), .ACC_W(16), .CNT_W(2)) u_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_last_i(in_last), .in_ready_o(c_in_ready), .out_valid_o(c_out_valid),
        .out_ready_i(out_ready), .out_sum_o(c_sum), .out_count_o(c_cnt), .out_ovf_o(c_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
    endtask

    function automatic longint total_of();
        longint t = 0;
        foreach (terms[i]) t += terms[i];
        return t;
    endfunction

    function automatic logic [31:0] exp_sum(input int acc_w);
        return 32'(total_of() % (64'd1 << acc_w));
    endfunction

    function automatic logic [31:0] exp_ovf(input int acc_w);
        return (total_of() >= (64'd1 << acc_w)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_cnt(input int cnt_w);
        longint mx = (64'd1 << cnt_w) - 1;
        return (terms.size() > mx) ? 32'(mx) : 32'(terms.size());
    endfunction

    // Feeds terms with occasional idle gaps carrying X data and a stray in_last.
    task automatic drive_burst(input bit gaps);
        for (int i = 0; i < terms.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 'x;
                in_last  = 1'($urandom_range(0, 1));
                tick();
            end
            in_valid = 1'b1;
            in_data  = terms[i];
            in_last  = (i == terms.size() - 1);
            tick();
        end
        idle_inputs();
    endtask

    task automatic check_result(input string tag);
        check({tag, " a_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, " a_ready"}, 32'(a_in_ready), 32'd0);
        check({tag, " a_sum"},   32'(a_sum), exp_sum(16));
        check({tag, " a_cnt"},   32'(a_cnt), exp_cnt(8));
        check({tag, " a_ovf"},   32'(a_ovf), exp_ovf(16));
        check({tag, " b_sum"},   32'(b_sum), exp_sum(8));
        check({tag, " b_cnt"},   32'(b_cnt), exp_cnt(8));
        check({tag, " b_ovf"},   32'(b_ovf), exp_ovf(8));
        check({tag, " c_sum"},   32'(c_sum), exp_sum(16));
        check({tag, " c_cnt"},   32'(c_cnt), exp_cnt(2));
        check({tag, " c_ovf"},   32'(c_ovf), exp_ovf(16));
    endtask

    // Holds off the consumer for `stall` cycles with junk offered upstream, then accepts.
    task automatic stall_and_accept(input string tag, input int stall);
        out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            in_data  = 'x;
            in_last  = 1'($urandom_range(0, 1));
            tick();
            check({tag, " stall ready"}, 32'(a_in_ready), 32'd0);
            check({tag, " stall valid"}, 32'(a_out_valid), 32'd1);
            check({tag, " stall sum"},   32'(a_sum), exp_sum(16));
            check({tag, " stall cnt"},   32'(a_cnt), exp_cnt(8));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        idle_inputs();
        check({tag, " acc valid"}, 32'(a_out_valid), 32'd0);
        check({tag, " acc ready"}, 32'(a_in_ready), 32'd1);
        check({tag, " acc keep"},  32'(a_sum), exp_sum(16));
    endtask

    task automatic run(input string tag, input int stall, input bit gaps);
        drive_burst(gaps);
        check_result(tag);
        stall_and_accept(tag, stall);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        check("rst valid", 32'(a_out_valid), 32'd0);
        check("rst ready", 32'(a_in_ready), 32'd1);
        check("rst sum",   32'(a_sum), 32'd0);
        check("rst cnt",   32'(a_cnt), 32'd0);
        check("rst ovf",   32'(a_ovf), 32'd0);

        terms = '{8'h0F, 8'h1E, 8'h2D};
        run("basic", 0, 1'b0);
        terms = '{8'hE1};
        run("single", 0, 1'b0);
        terms = '{8'h11, 8'h22};
        run("stall", 5, 1'b0);
        terms = '{8'hE1, 8'hE1};
        run("wrap8", 1, 1'b0);
        terms = '{8'h01};
        run("ovf clr", 0, 1'b0);
        terms = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        run("sat2", 0, 1'b0);
        terms.delete();
        for (int i = 0; i < 300; i++) terms.push_back(8'hFF);
        run("long", 0, 1'b0);

        // Partial burst interrupted by reset must be discarded.
        in_valid = 1'b1; in_data = 8'h30; in_last = 1'b0; tick();
        in_data  = 8'h40; tick();
        idle_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst ready", 32'(a_in_ready), 32'd1);
        terms = '{8'h04};
        drive_burst(1'b0);
        check_result("after rst");
        rst = 1'b1; tick(); rst = 1'b0;
        check("hold rst valid", 32'(a_out_valid), 32'd0);
        check("hold rst ready", 32'(a_in_ready), 32'd1);
        check("hold rst sum",   32'(a_sum), 32'd0);

        for (int r = 0; r < 20; r++) begin
            int n = $urandom_range(1, 40);
            terms.delete();
            for (int i = 0; i < n; i++) terms.push_back(8'($urandom_range(0, 255)));
            run($sformatf("rnd%0d", r), $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
